// File: rtl/csr_commit_ctrl_pkg.sv
// csr_commit_ctrl_pkg: CSR numbers, exception codes, ESTAT masks and sequencer state shared by the commit controller.
package csr_commit_ctrl_pkg;
  localparam logic [13:0] CSR_CRMD   = 14'h0;
  localparam logic [13:0] CSR_PRMD   = 14'h1;
  localparam logic [13:0] CSR_ESTAT  = 14'h5;
  localparam logic [13:0] CSR_ERA    = 14'h6;
  localparam logic [13:0] CSR_BADV   = 14'h7;
  localparam logic [13:0] CSR_EENTRY = 14'hc;
  localparam logic [5:0] ECODE_INT  = 6'h0;
  localparam logic [5:0] ECODE_ADEF = 6'h8;
  localparam logic [5:0] ECODE_ALE  = 6'h9;
  localparam logic [5:0] ECODE_SYS  = 6'hb;
  localparam logic [5:0] ECODE_BRK  = 6'hc;
  localparam logic [5:0] ECODE_INE  = 6'hd;
  localparam logic [31:0] ESTAT_ECODE_MASK    = 32'h003f_0000;
  localparam logic [31:0] ESTAT_ESUBCODE_MASK = 32'h7fc0_0000;
  typedef enum logic [2:0] {
    IDLE, EX_ERA, EX_ESTAT, EX_BADV, EX_PRMD, EX_CRMD, ERTN_CRMD, REDIR
  } state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [2:0]  crmd;
    logic [2:0]  prmd;
    logic [31:0] era;
    logic [31:0] eentry;
    logic        is_ex;
  } ctx_t;
endpackage

// File: rtl/csr_commit_ctrl_if.sv
// csr_commit_ctrl_if: writeback commit inputs, current CSR values, CSR write port and flush redirect.
interface csr_commit_ctrl_if #(parameter int CSR_NUM_W = 14);
  logic                 wb_valid;
  logic                 wb_ready;
  logic                 wb_csr_we;
  logic [CSR_NUM_W-1:0] wb_csr_num;
  logic [31:0]          wb_csr_wvalue;
  logic [31:0]          wb_csr_wmask;
  logic                 wb_ex;
  logic [5:0]           wb_ecode;
  logic [8:0]           wb_esubcode;
  logic [31:0]          wb_pc;
  logic [31:0]          wb_vaddr;
  logic                 wb_ertn;
  logic [31:0]          csr_crmd_rv;
  logic [31:0]          csr_prmd_rv;
  logic [31:0]          csr_era_rv;
  logic [31:0]          csr_eentry_rv;
  logic                 csr_we;
  logic [CSR_NUM_W-1:0] csr_num;
  logic [31:0]          csr_wvalue;
  logic [31:0]          csr_wmask;
  logic                 flush;
  logic [31:0]          flush_pc;
  modport slave (
    input  wb_valid, wb_csr_we, wb_csr_num, wb_csr_wvalue, wb_csr_wmask, wb_ex, wb_ecode,
           wb_esubcode, wb_pc, wb_vaddr, wb_ertn, csr_crmd_rv, csr_prmd_rv, csr_era_rv, csr_eentry_rv,
    output wb_ready, csr_we, csr_num, csr_wvalue, csr_wmask, flush, flush_pc
  );
  modport master (
    output wb_valid, wb_csr_we, wb_csr_num, wb_csr_wvalue, wb_csr_wmask, wb_ex, wb_ecode,
           wb_esubcode, wb_pc, wb_vaddr, wb_ertn, csr_crmd_rv, csr_prmd_rv, csr_era_rv, csr_eentry_rv,
    input  wb_ready, csr_we, csr_num, csr_wvalue, csr_wmask, flush, flush_pc
  );
endinterface

// File: rtl/csr_commit_ctrl_wr_mux.sv
// csr_wr_mux: picks CSR number, data and mask for the write belonging to a sequencer state.
module csr_wr_mux
  import csr_commit_ctrl_pkg::*;
#(
  parameter int CSR_NUM_W = 14
) (
  input  state_t               st,
  input  ctx_t                 ctx,
  input  logic [CSR_NUM_W-1:0] plain_num,
  input  logic [31:0]          plain_wvalue,
  input  logic [31:0]          plain_wmask,
  output logic [CSR_NUM_W-1:0] num,
  output logic [31:0]          wvalue,
  output logic [31:0]          wmask
);
  always_comb begin
    num = st == EX_ERA   ? CSR_NUM_W'(CSR_ERA)   :
          st == EX_ESTAT ? CSR_NUM_W'(CSR_ESTAT) :
          st == EX_BADV  ? CSR_NUM_W'(CSR_BADV)  :
          st == EX_PRMD  ? CSR_NUM_W'(CSR_PRMD)  :
          (st == EX_CRMD || st == ERTN_CRMD) ? CSR_NUM_W'(CSR_CRMD) : plain_num;
    wvalue = st == EX_ERA    ? ctx.pc :
             st == EX_ESTAT  ? {1'b0, ctx.esubcode, ctx.ecode, 16'b0} :
             st == EX_BADV   ? (ctx.ecode == ECODE_ADEF ? ctx.pc : ctx.vaddr) :
             st == EX_PRMD   ? {29'b0, ctx.crmd} :
             st == EX_CRMD   ? 32'b0 :
             st == ERTN_CRMD ? {29'b0, ctx.prmd} : plain_wvalue;
    wmask = (st == EX_ERA || st == EX_BADV) ? 32'hffff_ffff :
            st == EX_ESTAT ? (ESTAT_ECODE_MASK | ESTAT_ESUBCODE_MASK) :
            (st == EX_PRMD || st == EX_CRMD || st == ERTN_CRMD) ? 32'h7 : plain_wmask;
  end
endmodule

// File: rtl/csr_commit_ctrl.sv
// csr_commit_ctrl: owns the CSR write port; passes plain writes and expands exception/ERTN into write sequences plus a flush.
module csr_commit_ctrl
  import csr_commit_ctrl_pkg::*;
#(
  parameter int CSR_NUM_W    = 14,
  parameter int EENTRY_ALIGN = 6
) (
  input logic clk,
  input logic resetn,
  csr_commit_ctrl_if.slave bus
);
  localparam logic [31:0] EE_LOW = (32'd1 << EENTRY_ALIGN) - 32'd1;
  state_t               state, state_d;
  ctx_t                 ctx, ctx_d;
  logic                 acc, plain, we_d;
  logic [CSR_NUM_W-1:0] num_d;
  logic [31:0]          wvalue_d, wmask_d, redir_pc;
  logic                 unused_rv;
  assign unused_rv = ^{bus.csr_crmd_rv[31:3], bus.csr_prmd_rv[31:3]};
  // Outputs are registered from the next state so each write lands in the cycle its state is entered.
  always_comb begin
    acc = bus.wb_valid && state == IDLE;
    plain = acc && !bus.wb_ex && !bus.wb_ertn && bus.wb_csr_we;
    ctx_d = acc ? ctx_t'{pc: bus.wb_pc, vaddr: bus.wb_vaddr, ecode: bus.wb_ecode,
                         esubcode: bus.wb_esubcode, crmd: bus.csr_crmd_rv[2:0],
                         prmd: bus.csr_prmd_rv[2:0], era: bus.csr_era_rv,
                         eentry: bus.csr_eentry_rv, is_ex: bus.wb_ex} : ctx;
    state_d = state == IDLE     ? (acc && bus.wb_ex ? EX_ERA : acc && bus.wb_ertn ? ERTN_CRMD : IDLE) :
              state == EX_ERA   ? EX_ESTAT :
              state == EX_ESTAT ? ((ctx.ecode == ECODE_ADEF || ctx.ecode == ECODE_ALE) ? EX_BADV : EX_PRMD) :
              state == EX_BADV  ? EX_PRMD :
              state == EX_PRMD  ? EX_CRMD :
              (state == EX_CRMD || state == ERTN_CRMD) ? REDIR : IDLE;
    we_d = plain || !(state_d == IDLE || state_d == REDIR);
    redir_pc = ctx_d.is_ex ? ctx_d.eentry & ~EE_LOW : ctx_d.era;
  end
  csr_wr_mux #(.CSR_NUM_W(CSR_NUM_W)) u_mux (
    .st(state_d), .ctx(ctx_d), .plain_num(bus.wb_csr_num), .plain_wvalue(bus.wb_csr_wvalue),
    .plain_wmask(bus.wb_csr_wmask), .num(num_d), .wvalue(wvalue_d), .wmask(wmask_d)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      ctx            <= '0;
      bus.wb_ready   <= 1'b1;
      bus.csr_we     <= 1'b0;
      bus.csr_num    <= '0;
      bus.csr_wvalue <= '0;
      bus.csr_wmask  <= '0;
      bus.flush      <= 1'b0;
      bus.flush_pc   <= '0;
    end else begin
      state          <= state_d;
      ctx            <= ctx_d;
      bus.wb_ready   <= state_d == IDLE;
      bus.csr_we     <= we_d;
      bus.csr_num    <= we_d ? num_d : '0;
      bus.csr_wvalue <= we_d ? wvalue_d : '0;
      bus.csr_wmask  <= we_d ? wmask_d : '0;
      bus.flush      <= state_d == REDIR;
      bus.flush_pc   <= state_d == REDIR ? redir_pc : '0;
    end
  end
endmodule
